// File: rtl/rs_single_err_corr.sv
// Streaming RS(N,N-4) single-error corrector over GF(256), polynomial 0x11D.
// Define RS_SYND_OUT_EN to export the EVAL-time syndromes {S3,S2,S1,S0} on out_synd.
module rs_single_err_corr #(
   parameter int N = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [1:0]  out_status,
   output logic [4:0]  out_pos,
   output logic [7:0]  out_mag
`ifdef RS_SYND_OUT_EN
   ,
   output logic [31:0] out_synd
`endif
);

   localparam logic [4:0] LAST = 5'(N - 1);

   typedef enum logic [1:0] {ST_ACC, ST_EVAL, ST_SEARCH, ST_DONE} state_t;

   function automatic logic [7:0] gf256_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] gf256_mult(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf256_xtime(sh);
      end
      return acc;
   endfunction

   // a^254 by square-and-multiply: a^1 -> a^3 -> ... -> a^127, then one squaring.
   function automatic logic [7:0] gf256_inv(input logic [7:0] a);
      logic [7:0] t;
      t = a;
      for (int i = 0; i < 6; i++) begin
         t = gf256_mult(gf256_mult(t, t), a);
      end
      return gf256_mult(t, t);
   endfunction

   state_t     state, state_nxt;
   logic [4:0] cnt;
   logic [7:0] s0, s1, s2, s3;
   logic [7:0] x_reg, mag_reg, p_reg;
   logic [4:0] j_reg;
   logic       accept, all_zero, eval_bad;
   logic [7:0] x_eval;

   assign in_ready = (state == ST_ACC);
   assign accept   = in_valid && in_ready;
   assign all_zero = (s0 == 8'h00) && (s1 == 8'h00) && (s2 == 8'h00) && (s3 == 8'h00);
   assign x_eval   = gf256_mult(s1, gf256_inv(s0));
   assign eval_bad = (s0 == 8'h00) || (gf256_mult(s1, x_eval) != s2) ||
                     (gf256_mult(s2, x_eval) != s3);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_ACC;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACC:    if (accept && cnt == LAST) state_nxt = ST_EVAL;
         ST_EVAL:   state_nxt = (all_zero || eval_bad) ? ST_DONE : ST_SEARCH;
         ST_SEARCH: if (p_reg == x_reg || j_reg == LAST) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_ACC;
         default:   state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt        <= 5'd0;
         s0         <= 8'h00;
         s1         <= 8'h00;
         s2         <= 8'h00;
         s3         <= 8'h00;
         x_reg      <= 8'h00;
         mag_reg    <= 8'h00;
         p_reg      <= 8'h01;
         j_reg      <= 5'd0;
         out_valid  <= 1'b0;
         out_status <= 2'b00;
         out_pos    <= 5'd0;
         out_mag    <= 8'h00;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_ACC: begin
               if (accept) begin
                  s0  <= s0 ^ in_data;
                  s1  <= gf256_xtime(s1) ^ in_data;
                  s2  <= gf256_xtime(gf256_xtime(s2)) ^ in_data;
                  s3  <= gf256_xtime(gf256_xtime(gf256_xtime(s3))) ^ in_data;
                  cnt <= cnt + 5'd1;
               end
            end
            ST_EVAL: begin
               if (all_zero || eval_bad) begin
                  out_valid  <= 1'b1;
                  out_status <= all_zero ? 2'b00 : 2'b10;
                  out_pos    <= 5'd0;
                  out_mag    <= 8'h00;
               end else begin
                  x_reg   <= x_eval;
                  mag_reg <= s0;
                  p_reg   <= 8'h01;
                  j_reg   <= 5'd0;
               end
            end
            // p tracks alpha^j; a match at j means the error sits at degree j.
            ST_SEARCH: begin
               if (p_reg == x_reg) begin
                  out_valid  <= 1'b1;
                  out_status <= 2'b01;
                  out_pos    <= LAST - j_reg;
                  out_mag    <= mag_reg;
               end else if (j_reg == LAST) begin
                  out_valid  <= 1'b1;
                  out_status <= 2'b10;
                  out_pos    <= 5'd0;
                  out_mag    <= 8'h00;
               end else begin
                  p_reg <= gf256_xtime(p_reg);
                  j_reg <= j_reg + 5'd1;
               end
            end
            ST_DONE: begin
               cnt <= 5'd0;
               s0  <= 8'h00;
               s1  <= 8'h00;
               s2  <= 8'h00;
               s3  <= 8'h00;
            end
            default: ;
         endcase
      end
   end

`ifdef RS_SYND_OUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)                 out_synd <= 32'h0;
      else if (state == ST_EVAL) out_synd <= {s3, s2, s1, s0};
   end
`endif

endmodule

// File: doc/rs_single_err_corr.md
# rs_single_err_corr

Streaming Reed-Solomon single-error corrector for the CD CIRC decoder (C1 RS(32,28), or C2 RS(28,24) via parameter) over GF(256), polynomial 0x11D. It accumulates syndromes S0..S3 from a received codeword byte stream. It divides S1 by S0 using `gf256_inv` plus `gf256_mult` to get the error locator X. It then runs a sequential Chien-style search to turn X into a byte position. It sits between the de-interleaver and the byte corrector, and reports one verdict per codeword.

## Interface
- N, 32, codeword length in bytes (legal: 28 or 32); parity is fixed at 4 bytes.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte strobe; a byte is accepted when in_valid && in_ready.
- in_data  in  8  received byte, highest-degree coefficient first (stream index 0 = degree N-1).
- in_ready  out  1  high only in ACC state.
- out_valid  out  1  one-cycle verdict pulse.
- out_status  out  2  00 clean, 01 single error located, 10 uncorrectable; 11 never driven.
- out_pos  out  5  stream index of the erroneous byte (N-1-k); 0 unless status 01.
- out_mag  out  8  error value to XOR into that byte; 0 unless status 01.

## Operation
- Syndromes: Sj for j=0..3, Horner form Sj <= Sj·α^j ⊕ in_data on each accepted byte. Multiplication by the constants α^0..α^3 is fixed-constant XOR logic.
- Byte counter runs 0..N-1. The accept with count N-1 ends the codeword.
- States:
  - ACC: accept bytes. On the last byte go to EVAL.
  - EVAL (1 cycle): X = S1·inv(S0).
    - All Sj = 0 → DONE with status 00.
    - S0 = 0, or S2 ≠ S1·X, or S3 ≠ S2·X → DONE with status 10.
    - Otherwise register X and mag = S0, then go to SEARCH with j=0, p=1.
  - SEARCH: each cycle compare p == X.
    - On match, k=j; go to DONE with status 01 and pos = N-1-j.
    - On no match, p <= p·α and j <= j+1.
    - If j reaches N-1 without a match, go to DONE with status 10 (locator outside the shortened code).
  - DONE (1 cycle): out_valid=1 with the registered verdict. Clear the syndromes and counter, then return to ACC.
- Outputs are registered. out_status, out_pos and out_mag hold their last verdict until the next DONE.
- in_valid while in_ready=0 is ignored; the byte is dropped and the counter does not move.
- Reset (any state, including mid-codeword or mid-search):
  - state=ACC, counter=0, all Sj=0.
  - out_valid=0, out_status=00, out_pos=0, out_mag=0.
  - in_ready=1 in the cycle after reset deasserts.

## Timing
- Last byte accepted at cycle t. EVAL runs at t+1.
- Status 00, or status 10 decided in EVAL: out_valid at t+2.
- Status 01 at degree k: out_valid at t+3+k (worst case t+3+N-1).
- Status 10 from search exhaustion: out_valid at t+2+N.
- in_ready rises the cycle after the out_valid pulse. Back-to-back codewords have no other gap.
- The EVAL path is combinational: gf256_inv followed by two gf256_mult levels, in one cycle.

## Configuration
- RS_SYND_OUT_EN defined:
  - Adds output port out_synd [31:0] = {S3,S2,S1,S0}, registered in EVAL and held through DONE.
  - Valid when out_valid=1. Reset value 0.
  - Used by the downstream erasure/C2 flagging logic.
- RS_SYND_OUT_EN not defined: the port and its registers are absent. All other behaviour is identical.

## Test plan
- N=32, all-zero codeword streamed contiguously → out_valid at t+2, status 00, pos 0, mag 0.
- All-zero codeword with byte 0 = 0x5A (k=31) → status 01, pos 0, mag 0x5A, out_valid at t+34.
- All-zero codeword with byte 31 = 0x01 (k=0) → status 01, pos 31, mag 0x01, out_valid at t+3.
- Bytes 0 and 1 both 0x01 (S0=0, S1≠0) → status 10 at t+2. Bytes 3 = 0x11 and 20 = 0x07 → status 10 within t+2+N.
- i_rst pulsed after 10 bytes, then one clean codeword with random in_valid gaps → status 00, no verdict for the aborted word.
- N=28, byte 5 = 0xC3 → status 01, pos 5, mag 0xC3. With RS_SYND_OUT_EN, out_synd[7:0] = 0xC3 on the same pulse.
